// File: rtl/regs_mp.sv
// Multi-ported general-purpose register file with same-cycle write bypass and
// a per-register pending-write scoreboard (ID allocates, writeback retires).
module regs_mp #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 4,
  parameter int NW = 2,
  parameter int PW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NW-1:0]      we_i,
  input  logic [NW*AW-1:0]   waddr_i,
  input  logic [NW*DW-1:0]   wdata_i,
  input  logic [NR*AW-1:0]   raddr_i,
  output logic [NR*DW-1:0]   rdata_o,
  output logic [NR-1:0]      rbusy_o,
  input  logic               alloc_valid_i,
  input  logic [AW-1:0]      alloc_addr_i,
  output logic               alloc_ready_o,
  output logic               pend_any_o
);

  localparam int N  = 2**AW;
  localparam int RW = $clog2(NW + 1);
  localparam int CW = ((PW > RW) ? PW : RW) + 1;
  localparam logic [PW-1:0] CNT_MAX = '1;

  logic [DW-1:0] regs    [N];
  logic [PW-1:0] cnt     [N];
  logic [PW-1:0] avail   [N];
  logic [PW-1:0] cnt_nxt [N];
  logic          pend_nxt;

  // avail = count left after this cycle's retirements; a retire with nothing
  // outstanding is spurious and leaves the count at zero.
  always_comb begin : retire_calc
    logic [CW-1:0] ret;
    logic [CW-1:0] cur;
    for (int r = 0; r < N; r++) begin
      ret = '0;
      for (int k = 0; k < NW; k++) begin
        if (r != 0 && we_i[k] && waddr_i[k*AW +: AW] == AW'(r))
          ret = ret + CW'(1);
      end
      cur      = CW'(cnt[r]);
      avail[r] = (cur > ret) ? PW'(cur - ret) : '0;
    end
  end

  always_comb begin
    alloc_ready_o = !(alloc_valid_i && avail[alloc_addr_i] == CNT_MAX);
  end

  always_comb begin
    pend_nxt = 1'b0;
    for (int r = 0; r < N; r++) begin
      cnt_nxt[r] = avail[r];
      if (r != 0 && alloc_valid_i && alloc_ready_o && alloc_addr_i == AW'(r))
        cnt_nxt[r] = avail[r] + PW'(1);
      pend_nxt = pend_nxt | (cnt_nxt[r] != '0);
    end
  end

  // Later ports overwrite earlier ones, so the highest-index port wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      pend_any_o <= 1'b0;
    end else begin
      for (int r = 0; r < N; r++)
        cnt[r] <= cnt_nxt[r];
      for (int k = 0; k < NW; k++) begin
        if (we_i[k] && waddr_i[k*AW +: AW] != '0)
          regs[waddr_i[k*AW +: AW]] <= wdata_i[k*DW +: DW];
      end
      pend_any_o <= pend_nxt;
    end
  end

  always_comb begin : read_ports
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    rdata_o = '0;
    rbusy_o = '0;
    for (int j = 0; j < NR; j++) begin
      ra = raddr_i[j*AW +: AW];
      rd = regs[ra];
      for (int k = 0; k < NW; k++) begin
        if (we_i[k] && waddr_i[k*AW +: AW] == ra)
          rd = wdata_i[k*DW +: DW];
      end
      if (ra == '0)
        rd = '0;
      rdata_o[j*DW +: DW] = rd;
      rbusy_o[j]          = (avail[ra] != '0);
    end
  end

endmodule

// File: tb/tb_regs_mp.sv
// Self-checking bench for regs_mp: directed scenarios plus randomized traffic
// compared every cycle against an integer-array model of the register file.
module tb_regs_mp;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 4;
  localparam int NW   = 2;
  localparam int PW   = 2;
  localparam int N    = 2**AW;
  localparam int MAXC = 2**PW - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [NW-1:0]      we;
  logic [NW*AW-1:0]   waddr;
  logic [NW*DW-1:0]   wdata;
  logic [NR*AW-1:0]   raddr;
  logic [NR*DW-1:0]   rdata;
  logic [NR-1:0]      rbusy;
  logic               alloc_valid;
  logic [AW-1:0]      alloc_addr;
  logic               alloc_ready;
  logic               pend_any;

  regs_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .PW(PW)) dut (
    .clk(clk), .rst(rst),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
    .alloc_valid_i(alloc_valid), .alloc_addr_i(alloc_addr),
    .alloc_ready_o(alloc_ready), .pend_any_o(pend_any)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] m_regs [N];
  int            m_cnt  [N];
  bit            m_pend;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wa(int k);
    return int'(waddr[k*AW +: AW]);
  endfunction

  function automatic int retires(int r);
    int c = 0;
    if (r == 0) return 0;
    for (int k = 0; k < NW; k++)
      if (we[k] && wa(k) == r) c++;
    return c;
  endfunction

  function automatic int left(int r);
    int v = m_cnt[r] - retires(r);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic bit exp_ready();
    return !(alloc_valid && left(int'(alloc_addr)) == MAXC);
  endfunction

  function automatic logic [DW-1:0] exp_rdata(int a);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = m_regs[a];
    for (int k = 0; k < NW; k++)
      if (we[k] && wa(k) == a) v = wdata[k*DW +: DW];
    return v;
  endfunction

  // Reference model: plain integer counts and an array of register values.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        m_regs[r] = '0;
        m_cnt[r]  = 0;
      end
      m_pend = 1'b0;
    end else begin
      int nc [N];
      bit rdy;
      rdy = exp_ready();
      for (int r = 0; r < N; r++)
        nc[r] = left(r) + ((alloc_valid && rdy && r != 0 && int'(alloc_addr) == r) ? 1 : 0);
      for (int k = 0; k < NW; k++)
        if (we[k] && wa(k) != 0) m_regs[wa(k)] = wdata[k*DW +: DW];
      m_pend = 1'b0;
      for (int r = 0; r < N; r++) begin
        m_cnt[r] = nc[r];
        if (nc[r] != 0) m_pend = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int j = 0; j < NR; j++) begin
        checkOutput($sformatf("rdata%0d", j), 64'(rdata[j*DW +: DW]),
                    64'(exp_rdata(int'(raddr[j*AW +: AW]))));
        checkOutput($sformatf("rbusy%0d", j), 64'(rbusy[j]),
                    64'(left(int'(raddr[j*AW +: AW])) != 0));
      end
      checkOutput("alloc_ready", 64'(alloc_ready), 64'(exp_ready()));
      checkOutput("pend_any", 64'(pend_any), 64'(m_pend));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; alloc_valid = 1'b0; alloc_addr = '0;
  endtask

  task automatic setRead(input int r0, input int r1, input int r2, input int r3);
    raddr = {AW'(r3), AW'(r2), AW'(r1), AW'(r0)};
  endtask

  task automatic applyStimulus(input logic [NW-1:0] w, input int a0, input int a1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               input bit av, input int aa);
    we          = w;
    waddr       = {AW'(a1), AW'(a0)};
    wdata       = {d1, d0};
    alloc_valid = av;
    alloc_addr  = AW'(aa);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    setRead(0, 0, 0, 0);
    @(negedge clk);
    chk_en = 1'b1;
    checkOutput("reset_rdata", 64'(rdata), 64'(0));
    checkOutput("reset_rbusy", 64'(rbusy), 64'(0));
    checkOutput("reset_pend", 64'(pend_any), 64'(0));
    #2 rst = 1'b0;

    // Bypass on two ports; x0 write is ignored and x0 reads zero
    step();
    applyStimulus(2'b11, 3, 0, 32'hDEADBEEF, 32'h55, 1'b0, 0);
    setRead(3, 0, 0, 3);
    @(negedge clk);
    checkOutput("t2_rd0", 64'(rdata[0*DW +: DW]), 64'h0DEADBEEF);
    checkOutput("t2_rd3", 64'(rdata[3*DW +: DW]), 64'h0DEADBEEF);
    checkOutput("t2_rd_x0", 64'(rdata[1*DW +: DW]), 64'h0);

    // Two allocs of x7, then both ports retire; port 1 wins the data
    step(); applyStimulus(2'b00, 0, 0, 0, 0, 1'b1, 7);
    step(); applyStimulus(2'b00, 0, 0, 0, 0, 1'b1, 7);
    step(); applyStimulus(2'b11, 7, 7, 32'h11, 32'h22, 1'b0, 0);
    setRead(7, 7, 0, 0);
    @(negedge clk);
    checkOutput("t3_bypass", 64'(rdata[0*DW +: DW]), 64'h22);
    checkOutput("t3_busy_now", 64'(rbusy[0]), 64'h0);
    step(); idle();
    @(negedge clk);
    checkOutput("t3_rd_next", 64'(rdata[0*DW +: DW]), 64'h22);
    checkOutput("t3_busy_next", 64'(rbusy[0]), 64'h0);
    checkOutput("t3_model_cnt", 64'(m_cnt[7]), 64'h0);

    // Saturate x9, then a same-cycle retire frees the slot
    for (int i = 0; i < 3; i++) begin
      step(); applyStimulus(2'b00, 0, 0, 0, 0, 1'b1, 9);
    end
    step(); applyStimulus(2'b00, 0, 0, 0, 0, 1'b1, 9);
    setRead(9, 0, 0, 0);
    @(negedge clk);
    checkOutput("t4_full_ready", 64'(alloc_ready), 64'h0);
    checkOutput("t4_full_busy", 64'(rbusy[0]), 64'h1);
    step(); applyStimulus(2'b01, 9, 0, 32'h99, 0, 1'b1, 9);
    @(negedge clk);
    checkOutput("t4_retire_ready", 64'(alloc_ready), 64'h1);
    checkOutput("t4_retire_rd", 64'(rdata[0*DW +: DW]), 64'h99);
    step(); idle();
    @(negedge clk);
    checkOutput("t4_model_cnt", 64'(m_cnt[9]), 64'h3);
    checkOutput("t4_busy_after", 64'(rbusy[0]), 64'h1);

    // x4 at count 1: alloc and retire together
    step(); applyStimulus(2'b00, 0, 0, 0, 0, 1'b1, 4);
    setRead(4, 0, 0, 0);
    step(); applyStimulus(2'b01, 4, 0, 32'h44, 0, 1'b1, 4);
    @(negedge clk);
    checkOutput("t5_busy_now", 64'(rbusy[0]), 64'h0);
    checkOutput("t5_ready", 64'(alloc_ready), 64'h1);
    step(); idle();
    @(negedge clk);
    checkOutput("t5_model_cnt", 64'(m_cnt[4]), 64'h1);
    checkOutput("t5_busy_next", 64'(rbusy[0]), 64'h1);
    checkOutput("t5_pend_any", 64'(pend_any), 64'h1);

    // Spurious write to x6
    step(); applyStimulus(2'b10, 0, 6, 0, 32'hCAFE, 1'b0, 0);
    setRead(6, 0, 0, 0);
    step(); idle();
    @(negedge clk);
    checkOutput("t6_rd", 64'(rdata[0*DW +: DW]), 64'hCAFE);
    checkOutput("t6_busy", 64'(rbusy[0]), 64'h0);
    checkOutput("t6_model_cnt", 64'(m_cnt[6]), 64'h0);

    // Mid-run reset with x5 holding data and two pending writes
    step(); applyStimulus(2'b01, 5, 0, 32'h1234, 0, 1'b0, 0);
    step(); applyStimulus(2'b00, 0, 0, 0, 0, 1'b1, 5);
    step(); applyStimulus(2'b00, 0, 0, 0, 0, 1'b1, 5);
    step(); idle();
    setRead(5, 5, 5, 5);
    @(negedge clk);
    checkOutput("t1_pre_rd", 64'(rdata[0*DW +: DW]), 64'h1234);
    checkOutput("t1_pre_busy", 64'(rbusy), 64'hF);
    #1 rst = 1'b1;
    #1;
    checkOutput("t1_rst_rd", 64'(rdata), 64'h0);
    checkOutput("t1_rst_busy", 64'(rbusy), 64'h0);
    checkOutput("t1_rst_pend", 64'(pend_any), 64'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    step();
    @(negedge clk);
    checkOutput("t1_post_rd", 64'(rdata), 64'h0);
    checkOutput("t1_post_busy", 64'(rbusy), 64'h0);
    checkOutput("t1_post_pend", 64'(pend_any), 64'h0);

    // Randomized traffic on a small address window to force collisions
    for (int i = 0; i < 3000; i++) begin
      step();
      we = NW'($urandom);
      for (int k = 0; k < NW; k++) begin
        waddr[k*AW +: AW] = AW'($urandom_range(0, 7));
        wdata[k*DW +: DW] = DW'($urandom);
      end
      for (int j = 0; j < NR; j++)
        raddr[j*AW +: AW] = AW'($urandom_range(0, 7));
      alloc_valid = 1'($urandom_range(0, 1));
      alloc_addr  = AW'($urandom_range(0, 7));
      rst = ($urandom_range(0, 299) == 0);
    end
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regs_mp.md
Name: regs_mp

Overview:
- Parametrised successor to the core general-purpose register file.
- Supports NR combinational read ports and NW write ports, with same-cycle write-to-read bypass and an async-clearing register array.
- Adds a per-register pending-write scoreboard: ID allocates a destination, and each writeback retires one allocation. This lets multi-issue/out-of-order writeback hazards be detected inside the register file.
- Sits between ID (read/alloc) and the EX/LSU writeback ports.

Parameters:
- DW, 32, register data width
- AW, 5, register address width; number of registers N = 2**AW
- NR, 4, number of read ports
- NW, 2, number of write ports
- PW, 2, pending-count width per register; max outstanding writes per register = 2**PW-1

Ports:
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- we_i  in  NW  per-port write enable
- waddr_i  in  NW*AW  write addresses, port k at bits [k*AW +: AW]
- wdata_i  in  NW*DW  write data, port k at bits [k*DW +: DW]
- raddr_i  in  NR*AW  read addresses
- rdata_o  out  NR*DW  read data (combinational)
- rbusy_o  out  NR  read register still has pending writes after this cycle's retirements
- alloc_valid_i  in  1  ID requests destination allocation
- alloc_addr_i  in  AW  destination register to allocate
- alloc_ready_o  out  1  allocation accepted this cycle (combinational)
- pend_any_o  out  1  registered; 1 if any register has a nonzero pending count

Behaviour:
- **Reset:** rst high immediately clears all N registers to 0, all pending counts to 0, and pend_any_o to 0. Combinational outputs follow from the cleared state, so rdata_o = 0 and rbusy_o = 0. Reset asserted mid-operation discards all in-flight state. The first write is taken at the first posedge with rst low.
- **Register x0:** always reads 0, never written, never pending. alloc to x0 gives alloc_ready_o = 1 with no state change.
- **Write:** at posedge, for each k with we_i[k] and waddr_k != 0, regs[waddr_k] <= wdata_k.
  - Same address on several ports in the same cycle: the highest-index port wins the data.
- **Read (combinational):**
  - raddr = 0 -> 0.
  - Else, if any enabled write port targets raddr -> wdata of the highest-index matching port (bypass).
  - Else -> regs[raddr].
- **Pending count:** per register, cnt[r], PW bits.
  - retire[r] = number of ports k with we_i[k] and waddr_k = r (r != 0). Every matching port retires one allocation, including ports that lost the data priority.
  - alloc_hit[r] = alloc_valid_i & alloc_ready_o & (alloc_addr_i = r).
  - At posedge: cnt[r] <= cnt[r] - retire[r] + alloc_hit[r], computed at PW+1 bits.
  - Retire at cnt = 0 is a spurious write: count saturates at 0 and the data is still written.
- **alloc_ready_o** = 0 only when alloc_valid_i and cnt[alloc_addr_i] - retire[alloc_addr_i] = 2**PW-1. A same-cycle retire frees a slot. A rejected alloc changes no state; ID holds and retries.
- **rbusy_o[j]** = (cnt[raddr_j] - retire[raddr_j]) != 0, evaluated before this cycle's alloc. A read bypassing its final pending write shows busy = 0.
- **pend_any_o:** registered OR of all next-state counts.
- **Timing:** no read latency (same cycle); scoreboard state updates one cycle after alloc or retire.
- **Other rules:**
  - No X propagation from unused ports.
  - All widths are generic; NR, NW ≥ 1.

Test Plan:
1. Assert rst mid-run with cnt[x5] = 2 and regs[x5] = 0x1234 -> all rdata_o = 0, rbusy_o = 0 and pend_any_o = 0 while rst is high, and after release.
2. Write x3 = 0xDEADBEEF on port 0 while reading x3 on ports 0 and 3 -> both return 0xDEADBEEF in the same cycle; a read of x0 stays 0 during a write to x0.
3. Ports 0 and 1 both write x7 (0x11, 0x22) in one cycle after two allocs of x7 -> next cycle regs[x7] = 0x22, cnt[x7] = 0, rbusy = 0.
4. Alloc x9 three times (PW = 2) -> fourth alloc gives alloc_ready_o = 0 and cnt stays 3. Repeat the fourth alloc with a same-cycle write to x9 -> ready = 1, cnt stays 3.
5. Alloc x4 and a write of x4 in the same cycle with cnt = 1 -> rbusy for x4 = 0 in that cycle, cnt = 1 the next cycle, and pend_any_o = 1.
6. Spurious write to x6 at cnt = 0 -> data written (0xCAFE read next cycle) and cnt stays 0.
